i2c_slave_regs: RTL and testbench
=================================

# i2c_slave_regs

Clocked I2C target (slave) that answers an I2C master on the same open-drain SCL/SDA pair the master's IO buffer drives. SCL and SDA are sampled and filtered on the system clock, START/STOP are detected, and a 7-bit address is matched. A register-pointer byte is accepted, and bytes are written to or read from an external byte-wide register bus with auto-increment. The block never stretches SCL.

## Interface
- `SLV_ADDR`, default 7'h50: 7-bit target address.
- `REG_AW`, default 4: register pointer width; register space is 2^REG_AW bytes.
- `clk` in 1: system clock; must be at least 16× the SCL frequency.
- `rst` in 1: asynchronous, active-high reset.
- `scl_i` in 1: SCL line level from the IO buffer.
- `sda_i` in 1: SDA line level from the IO buffer.
- `sda_e` out 1: SDA pull-down enable. 1 drives the line low; 0 releases it to the pull-up.
- `reg_addr` out REG_AW: register pointer presented with `reg_we`/`reg_re`.
- `reg_wdata` out 8: write byte, valid while `reg_we`=1.
- `reg_we` out 1: one-cycle write strobe.
- `reg_re` out 1: one-cycle read request. The block samples `reg_rdata` on the next clk.
- `reg_rdata` in 8: read byte returned by the register bus.
- `busy` out 1: high from an accepted address match until STOP or address mismatch.

## Operation
- **Input conditioning:** 2-FF synchronizer on `scl_i` and `sda_i`, followed by a 1-cycle glitch filter. An output changes only when two consecutive synced samples agree. Edges are detected on the filtered signals.
- **START/Sr:** SDA falls while SCL is high. Valid in any state; goes to ADDR, bit count = 0.
- **STOP:** SDA rises while SCL is high. Valid in any state; goes to IDLE, `sda_e`=0, `busy`=0.
- Data bits are sampled on the SCL rising edge, MSB first.
- `sda_e` changes only on the clk after an SCL falling edge is detected.
- **States and transitions:**
  - IDLE: wait for START.
  - ADDR: shift in 8 bits.
    - bits[7:1]==SLV_ADDR → ADDR_ACK, with `busy`=1.
    - Mismatch → IGNORE; no ACK is driven.
  - ADDR_ACK: drive `sda_e`=1 for one SCL period.
    - R/W=0 → PTR.
    - R/W=1 → RDATA. `reg_re` pulses on the SCL rising edge of the ACK slot using the current pointer; the byte is latched into the shift register.
  - PTR: shift in 8 bits, then pointer = byte[REG_AW-1:0]. Go to PTR_ACK, which drives an ACK, then WDATA.
  - WDATA: on the 8th SCL rise, pulse `reg_we` for one cycle with `reg_addr`=pointer and `reg_wdata`=byte. Then pointer+1, ACK, and back to WDATA.
  - RDATA: drive each bit as `sda_e` = !bit. After the 8th bit, release SDA, pointer+1, go to MACK.
  - MACK: sample SDA on SCL rise.
    - 0 (ACK): pulse `reg_re` at the new pointer, latch, → RDATA.
    - 1 (NACK): → IGNORE.
  - IGNORE: `sda_e`=0. Wait for STOP or Sr.
- The pointer wraps modulo 2^REG_AW. The pointer persists across transactions and resets to 0.
- Writing past the PTR byte with no data bytes is legal; no `reg_we` is issued.
- A STOP or Sr mid-byte discards partial bits; no strobe is issued.

## Timing
- **Reset values:** `sda_e`=0, `reg_we`=0, `reg_re`=0, `reg_addr`=0, `reg_wdata`=0, `busy`=0, state IDLE, pointer 0.
- **Input latency:** line to filtered edge detect is 3 clk.
- **SDA output:** `sda_e` updates 4 clk after the SCL line falls. It is held until the next SCL falling detection, STOP, or reset.
- **Write strobe:** `reg_we` asserts 4 clk after the 8th SCL rise of a data byte.
- **Read request:** `reg_re` asserts 4 clk after the relevant SCL rise. `reg_rdata` must be valid on the following clk.
- **Strobe width:** `reg_we` and `reg_re` are each exactly 1 clk per byte and never both high in the same cycle.
- **Reset mid-transfer:** SDA is released immediately, asynchronously. The block ignores the bus until the next START.

## Structure
- Shared package `i2c_pkg`:
  - state enum (IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, MACK, IGNORE);
  - constant `I2C_BYTE_W`=8.
- Sub-module `i2c_line_filter`: synchronizer, glitch filter, and rise/fall/START/STOP strobe generation for one SCL/SDA pair.

## Test plan
- START, 0xA0, 0x03, 0xA5, 0x5A, STOP → ACKs on every byte; `reg_we` at addr 3 with 0xA5, then addr 4 with 0x5A; pointer ends at 5.
- Write pointer 0x02, then Sr, 0xA1, read 2 bytes with master ACK then NACK; `reg_rdata` = 0x11 then 0x22 → SDA carries 0x11, 0x22; `reg_re` at addr 2 then 3; IGNORE until STOP.
- START, 0xA2 (address mismatch) → `sda_e` stays 0 throughout, no strobes, `busy`=0.
- Pointer 0x0F, write 0x77, 0x88 → `reg_we` at addr 15 then addr 0 (wrap).
- STOP after 4 bits of a data byte → no `reg_we`, IDLE, `sda_e`=0. Then assert `rst` during the ACK slot of the next transfer → `sda_e`=0 in the same cycle as reset, all outputs at reset values.
- 1-clk SDA glitch while SCL is high → no false START/STOP detected.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, MACK, IGNORE
  } i2c_state_e;
endpackage

// File: rtl/i2c_slave_regs_if.sv
// Line-side and register-bus signals of the I2C register target.
interface i2c_slave_regs_if
  import i2c_pkg::*;
#(
  parameter int REG_AW = 4
);
  logic                  scl_i;
  logic                  sda_i;
  logic                  sda_e;
  logic [REG_AW-1:0]     reg_addr;
  logic [I2C_BYTE_W-1:0] reg_wdata;
  logic                  reg_we;
  logic                  reg_re;
  logic [I2C_BYTE_W-1:0] reg_rdata;
  logic                  busy;

  modport slave  (input  scl_i, sda_i, reg_rdata,
                  output sda_e, reg_addr, reg_wdata, reg_we, reg_re, busy);
  modport master (output scl_i, sda_i, reg_rdata,
                  input  sda_e, reg_addr, reg_wdata, reg_we, reg_re, busy);
endinterface

// File: rtl/i2c_line_filter.sv
// Synchronizes and deglitches an SCL/SDA pair; emits SCL edge and START/STOP strobes.
module i2c_line_filter (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);
  // bit 1 = SCL, bit 0 = SDA; idle bus level is high so reset to ones
  logic [1:0] s1_q, s2_q, s3_q, filt_q, filt_d;
  logic [1:0] agree, rise, fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 2'b11;
      s2_q   <= 2'b11;
      s3_q   <= 2'b11;
      filt_q <= 2'b11;
    end else begin
      s1_q   <= {scl_i, sda_i};
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      filt_q <= filt_d;
    end
  end

  always_comb begin
    agree  = ~(s2_q ^ s3_q);
    filt_d = (agree & s2_q) | (~agree & filt_q);
    rise   = filt_d & ~filt_q;
    fall   = ~filt_d & filt_q;
  end

  assign sda_o      = filt_q[0];
  assign scl_rise_o = rise[1];
  assign scl_fall_o = fall[1];
  assign start_o    = fall[0] & filt_q[1] & filt_d[1];
  assign stop_o     = rise[0] & filt_q[1] & filt_d[1];
endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target with a register pointer and auto-incrementing byte register bus.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR = 7'h50,
  parameter int         REG_AW   = 4
) (
  input logic             clk,
  input logic             rst,
  i2c_slave_regs_if.slave bus
);
  logic sda_f, scl_rise, scl_fall, start, stop;

  i2c_line_filter u_filt (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (bus.scl_i),
    .sda_i      (bus.sda_i),
    .sda_o      (sda_f),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop)
  );

  i2c_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [I2C_BYTE_W-1:0] sh_q, sh_d, wdata_q, wdata_d;
  logic [REG_AW-1:0]     ptr_q, ptr_d, addr_q, addr_d;
  logic                  rw_q, rw_d, sda_e_q, sda_e_d, busy_q, busy_d;
  logic                  we_q, we_d, re_q, re_d;
  logic [I2C_BYTE_W-1:0] byte_in;

  assign byte_in = {sh_q[6:0], sda_f};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      wdata_q <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      sda_e_q <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      wdata_q <= wdata_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      sda_e_q <= sda_e_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      re_q    <= re_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    wdata_d = wdata_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    sda_e_d = sda_e_q;
    busy_d  = busy_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    if (stop) begin
      state_d = IDLE;
      sda_e_d = 1'b0;
      busy_d  = 1'b0;
    end else if (start) begin
      state_d = ADDR;
      cnt_d   = '0;
      sda_e_d = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            rw_d  = byte_in[0];
            if (byte_in[7:1] == SLV_ADDR) begin
              state_d = ADDR_ACK;
              busy_d  = 1'b1;
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        PTR, WDATA: if (scl_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            if (state_q == PTR) begin
              ptr_d   = byte_in[REG_AW-1:0];
              state_d = PTR_ACK;
            end else begin
              we_d    = 1'b1;
              addr_d  = ptr_q;
              wdata_d = byte_in;
              ptr_d   = ptr_q + REG_AW'(1);
              state_d = WDATA_ACK;
            end
          end
        end
        // cnt marks whether the ACK is already on the line (0: first fall drives it)
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              sda_e_d = 1'b1;
              cnt_d   = 4'd1;
            end else begin
              sda_e_d = 1'b0;
              cnt_d   = '0;
              state_d = (state_q == ADDR_ACK) ? PTR : WDATA;
            end
          end else if (scl_rise && state_q == ADDR_ACK && rw_q && cnt_q == 4'd1) begin
            state_d = RDATA;
            cnt_d   = '0;
            re_d    = 1'b1;
            addr_d  = ptr_q;
          end
        end
        RDATA: if (scl_fall) begin
          if (cnt_q != 4'd8) begin
            sda_e_d = ~sh_q[7];
            sh_d    = {sh_q[6:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
          end else begin
            sda_e_d = 1'b0;
            cnt_d   = '0;
            ptr_d   = ptr_q + REG_AW'(1);
            state_d = MACK;
          end
        end
        MACK: if (scl_rise) begin
          if (!sda_f) begin
            state_d = RDATA;
            cnt_d   = '0;
            re_d    = 1'b1;
            addr_d  = ptr_q;
          end else begin
            state_d = IGNORE;
          end
        end
        IGNORE:  sda_e_d = 1'b0;
        default: ;
      endcase
    end
    // read data comes back one clk after the request
    if (re_q) sh_d = bus.reg_rdata;
  end

  assign bus.sda_e     = sda_e_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench: bit-banged I2C master plus a transaction-level pointer/register model.
module tb_i2c_slave_regs;
  localparam logic [6:0] SLV = 7'h50;

  logic clk = 1'b0;
  logic rst;
  logic scl_m, sda_m, glitch, quiet, quiet_bad;
  logic [7:0]  regs [16];
  logic [3:0]  m_ptr;
  logic [11:0] exp_we [$];
  logic [3:0]  exp_re [$];
  logic [7:0]  dq [$];
  logic [7:0]  rq [$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  i2c_slave_regs_if #(.REG_AW(4)) bus ();

  assign bus.scl_i     = scl_m;
  assign bus.sda_i     = sda_m & ~bus.sda_e;
  assign bus.reg_rdata = regs[bus.reg_addr];

  i2c_slave_regs #(.SLV_ADDR(SLV), .REG_AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Strobe checker: every write/read request must match the model's queue in order
  always @(negedge clk) begin
    if (!rst) begin
      if (quiet && bus.sda_e) quiet_bad = 1'b1;
      if (bus.reg_we && bus.reg_re) begin
        tests++; fails++;
        $display("FAIL strobe_overlap: we=1 re=1 want not both at %0t", $time);
      end
      if (bus.reg_we) begin
        if (exp_we.size() == 0) begin
          tests++; fails++;
          $display("FAIL we_spurious: addr %0h data %0h want none", bus.reg_addr, bus.reg_wdata);
        end else chk("we_addr_data", {bus.reg_addr, bus.reg_wdata}, exp_we.pop_front());
      end
      if (bus.reg_re) begin
        if (exp_re.size() == 0) begin
          tests++; fails++;
          $display("FAIL re_spurious: addr %0h want none", bus.reg_addr);
        end else chk("re_addr", bus.reg_addr, exp_re.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time %0t want finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_wr(input logic b);
    clk_n(5); sda_m = b; clk_n(5); scl_m = 1'b1;
    if (glitch) begin
      clk_n(3); sda_m = ~b; clk_n(1); sda_m = b; clk_n(6);
    end else clk_n(10);
    scl_m = 1'b0;
  endtask

  task automatic bit_rd(output logic b);
    clk_n(5); sda_m = 1'b1; clk_n(5); scl_m = 1'b1;
    clk_n(5); b = bus.sda_i; clk_n(5); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    clk_n(5); sda_m = 1'b1; clk_n(5); scl_m = 1'b1;
    clk_n(5); sda_m = 1'b0; clk_n(10); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    clk_n(5); sda_m = 1'b0; clk_n(5); scl_m = 1'b1;
    clk_n(5); sda_m = 1'b1; clk_n(10);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) bit_wr(b[i]);
    bit_rd(ack);
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic nack);
    logic bt;
    for (int i = 7; i >= 0; i--) begin bit_rd(bt); b[i] = bt; end
    bit_wr(nack);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sda_e"}, bus.sda_e, 0);
    chk({tag, "_we"}, bus.reg_we, 0);
    chk({tag, "_re"}, bus.reg_re, 0);
    chk({tag, "_addr"}, bus.reg_addr, 0);
    chk({tag, "_wdata"}, bus.reg_wdata, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  // Write transaction: pointer byte p, then the bytes queued in dq
  task automatic do_write(input logic [7:0] p);
    logic ack;
    i2c_start();
    send_byte({SLV, 1'b0}, ack); chk("w_addr_ack", ack, 0);
    chk("w_busy", bus.busy, 1);
    send_byte(p, ack); chk("w_ptr_ack", ack, 0);
    m_ptr = p[3:0];
    foreach (dq[i]) begin
      exp_we.push_back({m_ptr, dq[i]});
      regs[m_ptr] = dq[i];
      m_ptr = m_ptr + 4'd1;
      send_byte(dq[i], ack); chk("w_data_ack", ack, 0);
    end
    i2c_stop();
    chk("w_busy_stop", bus.busy, 0);
  endtask

  // Read n bytes, optionally after setting the pointer and a repeated START
  task automatic do_read(input bit set_ptr, input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] b;
    rq.delete();
    i2c_start();
    if (set_ptr) begin
      send_byte({SLV, 1'b0}, ack); chk("r_waddr_ack", ack, 0);
      send_byte(p, ack); chk("r_ptr_ack", ack, 0);
      m_ptr = p[3:0];
      i2c_start();
    end
    exp_re.push_back(m_ptr);
    send_byte({SLV, 1'b1}, ack); chk("r_addr_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      if (i < n - 1) exp_re.push_back(m_ptr + 4'd1);
      recv_byte(b, (i == n - 1));
      chk("r_data", b, regs[m_ptr]);
      rq.push_back(b);
      m_ptr = m_ptr + 4'd1;
    end
    i2c_stop();
    chk("r_busy_stop", bus.busy, 0);
  endtask

  task automatic do_mismatch(input logic [6:0] a, input logic rw);
    logic ack;
    quiet = 1'b1; quiet_bad = 1'b0;
    i2c_start();
    send_byte({a, rw}, ack); chk("mm_addr_nack", ack, 1);
    chk("mm_busy", bus.busy, 0);
    send_byte(8'($urandom), ack); chk("mm_data_nack", ack, 1);
    i2c_stop();
    quiet = 1'b0;
    chk("mm_sda_quiet", quiet_bad, 0);
  endtask

  initial begin
    logic ack;
    logic [6:0] a;
    int kind;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; glitch = 1'b0;
    quiet = 1'b0; quiet_bad = 1'b0; m_ptr = '0;
    for (int i = 0; i < 16; i++) regs[i] = 8'($urandom);
    clk_n(5);
    chk_reset_vals("reset");
    rst = 1'b0;
    clk_n(10);

    // Write two bytes from pointer 3
    dq = '{8'hA5, 8'h5A};
    do_write(8'h03);
    chk("model_ptr_after_write", m_ptr, 4'h5);
    do_read(1'b0, 8'h00, 1);

    // Pointer 2, repeated START, read two bytes
    regs[2] = 8'h11; regs[3] = 8'h22;
    do_read(1'b1, 8'h02, 2);
    chk("read_byte0", rq[0], 8'h11);
    chk("read_byte1", rq[1], 8'h22);

    do_mismatch(7'h51, 1'b0);

    // Pointer wrap
    dq = '{8'h77, 8'h88};
    do_write(8'h0F);
    chk("model_ptr_wrap", m_ptr, 4'h1);

    // STOP after 4 data bits: no strobe, pointer unchanged
    i2c_start();
    send_byte({SLV, 1'b0}, ack); chk("ms_addr_ack", ack, 0);
    send_byte(8'h09, ack); chk("ms_ptr_ack", ack, 0);
    m_ptr = 4'h9;
    for (int i = 0; i < 4; i++) bit_wr(i[0]);
    i2c_stop();
    chk("ms_sda_e", bus.sda_e, 0);
    chk("ms_busy", bus.busy, 0);

    // Reset while the address ACK is on the line
    i2c_start();
    for (int i = 7; i >= 1; i--) bit_wr(SLV[i-1]);
    bit_wr(1'b0);
    clk_n(6);
    chk("ack_driven_before_rst", bus.sda_e, 1);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    sda_m = 1'b1; clk_n(5); scl_m = 1'b1; clk_n(10);
    rst = 1'b0;
    m_ptr = '0;
    clk_n(10);
    do_read(1'b0, 8'h00, 1);

    // 1-clk SDA glitches on every master bit while SCL is high
    glitch = 1'b1;
    dq = '{8'h3C};
    do_write(8'h06);
    glitch = 1'b0;
    do_read(1'b1, 8'h06, 1);
    chk("glitch_readback", rq[0], 8'h3C);

    // Randomized transactions
    for (int it = 0; it < 20; it++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          dq.delete();
          for (int j = 0; j < $urandom_range(0, 3); j++) dq.push_back(8'($urandom));
          do_write(8'($urandom));
        end
        1: do_read(1'b1, 8'($urandom), $urandom_range(1, 3));
        2: do_read(1'b0, 8'h00, $urandom_range(1, 3));
        default: begin
          a = 7'($urandom);
          if (a == SLV) a = SLV + 7'd1;
          do_mismatch(a, 1'($urandom));
        end
      endcase
    end

    clk_n(20);
    chk("we_queue_drained", exp_we.size(), 0);
    chk("re_queue_drained", exp_re.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
